// File: rtl/jtag_mem_ctrl.sv
// Memory-side responder for the JTAG programming path: synchronizes the tck-domain
// sel request, performs a wait-stated access on a 256x16 array, then closes the handshake.
module jtag_mem_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        mem_clk,
    input  logic        mem_rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic [15:0] rdata,
    input  logic [7:0]  dbg_addr,
    output logic [15:0] dbg_rdata
);

    // state   | meaning
    // IDLE    | ready high, waiting for a synchronized request
    // ACCESS  | ready low, counting wait states; commit on count zero
    // RELEASE | ready high, waiting for the request to drop
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sel_s;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q;
    logic [7:0]         addr_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rdata_q;
    logic               latch;
    logic               commit;
    logic               mem_we;
    logic               mem_re;
    logic [15:0]        mem [256];

    assign sel_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sel};
        end
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_s) begin
                    latch   = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!sel_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = commit & we_q;
    assign mem_re = commit & ~we_q;

    // Request fields are only trusted at the sel_s rising point; later changes are ignored.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (latch) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (mem_re) begin
                rdata_q <= mem[addr_q];
            end
        end
    end

    // Array is deliberately not reset so contents survive mem_rst_n.
    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign ready     = (state_q != ACCESS);
    assign rdata     = rdata_q;
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Directed plus randomized bench for jtag_mem_ctrl; two instances (2 and 0 wait states)
// are checked against a plain array model of memory and handshake timing.
module tb_jtag_mem_ctrl;

    localparam int WS0  = 2;
    localparam int WS1  = 0;
    localparam int SYNC = 2;

    logic        mem_clk = 1'b0;
    logic        mem_rst_n;
    logic        sel0, sel1;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  dbg_addr;
    logic        ready0, ready1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] dbg_rdata0, dbg_rdata1;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [15:0] model0 [256];
    logic [15:0] model1 [256];
    logic [15:0] exp_rd0, exp_rd1;
    logic [7:0]  written0 [$];
    logic [7:0]  written1 [$];

    always #5 mem_clk = ~mem_clk;

    jtag_mem_ctrl #(.WAIT_STATES(WS0), .SYNC_STAGES(SYNC)) dut0 (
        .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .sel(sel0), .we(we),
        .addr(addr), .wdata(wdata), .ready(ready0), .rdata(rdata0),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata0)
    );

    jtag_mem_ctrl #(.WAIT_STATES(WS1), .SYNC_STAGES(SYNC)) dut1 (
        .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .sel(sel1), .we(we),
        .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? ready0 : ready1;
    endfunction

    // One full four-phase transaction on the selected instance, then sel low for gap+1 cycles.
    task automatic access(input int which, input logic w, input logic [7:0] a,
                          input logic [15:0] d, input int hold, input int gap);
        int cnt;
        int low;
        bit held_ok;
        logic [15:0] exp_rd;
        logic [15:0] exp_mem;
        @(negedge mem_clk);
        we    = w;
        addr  = a;
        wdata = d;
        if (which == 0) sel0 = 1'b1; else sel1 = 1'b1;
        cnt = 0;
        do begin
            @(negedge mem_clk);
            cnt++;
        end while (rdy(which) && cnt < 20);
        check("sel_to_ready_fall", cnt, SYNC + 1);
        low = 0;
        while (!rdy(which) && low < 40) begin
            @(negedge mem_clk);
            low++;
        end
        check("ready_low_cycles", low, ((which == 0) ? WS0 : WS1) + 1);
        if (which == 0) begin
            if (w) model0[a] = d; else exp_rd0 = model0[a];
            exp_rd  = exp_rd0;
            exp_mem = model0[a];
            if (w && !(a inside {written0})) written0.push_back(a);
        end else begin
            if (w) model1[a] = d; else exp_rd1 = model1[a];
            exp_rd  = exp_rd1;
            exp_mem = model1[a];
            if (w && !(a inside {written1})) written1.push_back(a);
        end
        check(w ? "rdata_unchanged_on_write" : "rdata_on_read",
              (which == 0) ? rdata0 : rdata1, exp_rd);
        dbg_addr = a;
        #1;
        check("dbg_after_access", (which == 0) ? dbg_rdata0 : dbg_rdata1, exp_mem);
        if (hold > 0) begin
            held_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                if (i == 2) begin
                    we    = 1'b1;
                    addr  = 8'h10;
                    wdata = 16'hFFFF;
                end
                @(negedge mem_clk);
                if (!rdy(which)) held_ok = 1'b0;
            end
            check("held_sel_single_access", held_ok, 1'b1);
        end
        if (which == 0) sel0 = 1'b0; else sel1 = 1'b0;
        repeat (gap) @(negedge mem_clk);
    endtask

    task automatic check_dbg(input string tag, input int which, input logic [7:0] a);
        dbg_addr = a;
        #1;
        check(tag, (which == 0) ? dbg_rdata0 : dbg_rdata1,
              (which == 0) ? model0[a] : model1[a]);
    endtask

    initial begin
        bit stayed;
        int cnt;
        logic [7:0]  ra;
        logic [15:0] rd;

        mem_rst_n = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0;
        we = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;
        exp_rd0 = '0; exp_rd1 = '0;

        repeat (3) @(negedge mem_clk);
        check("reset_ready0", ready0, 1'b1);
        check("reset_rdata0", rdata0, 16'h0000);
        check("reset_ready1", ready1, 1'b1);
        check("reset_rdata1", rdata1, 16'h0000);
        mem_rst_n = 1'b1;

        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge mem_clk);
            if (!ready0 || !ready1) stayed = 1'b0;
        end
        check("idle_ready_stays_high", stayed, 1'b1);

        // Write then read back.
        access(0, 1'b1, 8'h3C, 16'hA55A, 0, 4);
        access(0, 1'b0, 8'h3C, 16'h0000, 0, 4);
        check("read_3c", rdata0, 16'hA55A);

        // Held sel with field changes during the hold.
        access(0, 1'b1, 8'h10, 16'h0BAD, 0, 4);
        access(0, 1'b1, 8'h20, 16'h1357, 50, 4);
        check_dbg("hold_no_write_10", 0, 8'h10);
        check_dbg("hold_write_20", 0, 8'h20);

        // Back-to-back writes at the minimum sel gap, bottom and top words.
        access(0, 1'b1, 8'h00, 16'h0001, 0, 2);
        access(0, 1'b1, 8'hFF, 16'hFFFE, 0, 4);
        check_dbg("b2b_word_00", 0, 8'h00);
        check_dbg("b2b_word_ff", 0, 8'hFF);

        // Reset during the second ACCESS cycle drops the pending write.
        access(0, 1'b1, 8'h05, 16'hBEEF, 0, 4);
        @(negedge mem_clk);
        we = 1'b1; addr = 8'h05; wdata = 16'h1234; sel0 = 1'b1;
        cnt = 0;
        do begin
            @(negedge mem_clk);
            cnt++;
        end while (ready0 && cnt < 20);
        check("rst_mid_ready_fell", ready0, 1'b0);
        @(negedge mem_clk);
        mem_rst_n = 1'b0;
        sel0 = 1'b0;
        #1;
        check("rst_mid_ready", ready0, 1'b1);
        check("rst_mid_rdata", rdata0, 16'h0000);
        exp_rd0 = '0;
        exp_rd1 = '0;
        repeat (2) @(negedge mem_clk);
        mem_rst_n = 1'b1;
        repeat (4) @(negedge mem_clk);
        check_dbg("rst_mid_mem_kept", 0, 8'h05);

        // Zero-wait-state instance.
        access(1, 1'b1, 8'h3C, 16'hC3C3, 0, 4);
        access(1, 1'b0, 8'h3C, 16'h0000, 0, 4);
        check("ws0_read_3c", rdata1, 16'hC3C3);

        // Randomized traffic; reads only target words the model knows.
        for (int i = 0; i < 40; i++) begin
            if (written0.size() > 0 && $urandom_range(1, 0) == 0) begin
                ra = written0[$urandom_range(written0.size() - 1, 0)];
                access(0, 1'b0, ra, 16'($urandom), 0, $urandom_range(6, 2));
            end else begin
                ra = 8'($urandom);
                rd = 16'($urandom);
                access(0, 1'b1, ra, rd, 0, $urandom_range(6, 2));
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (written1.size() > 0 && $urandom_range(1, 0) == 0) begin
                ra = written1[$urandom_range(written1.size() - 1, 0)];
                access(1, 1'b0, ra, 16'($urandom), 0, $urandom_range(6, 2));
            end else begin
                ra = 8'($urandom);
                rd = 16'($urandom);
                access(1, 1'b1, ra, rd, 0, $urandom_range(6, 2));
            end
        end
        foreach (written0[i]) check_dbg("final_mem0", 0, written0[i]);
        foreach (written1[i]) check_dbg("final_mem1", 1, written1[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/jtag_mem_ctrl.md
# jtag_mem_ctrl

Memory-side responder for the JTAG programming path. It receives `sel`/`we`/`addr`/`wdata` requests from the JTAG controller, which runs in the `tck` domain, and synchronizes them into its own clock domain. It performs the access on an internal 256x16 memory with programmable wait states, then completes the four-phase handshake by returning `ready` and, for reads, `rdata`.

## Interface
- `WAIT_STATES`, default 2: extra access cycles; `ready` stays low for `WAIT_STATES+1` clocks per access. Legal range 0..15.
- `SYNC_STAGES`, default 2: flip-flop depth of the `sel` synchronizer. Minimum 2.
- `mem_clk`  in  1  memory-side clock; all state updates on rising edge.
- `mem_rst_n`  in  1  asynchronous active-low reset.
- `sel`  in  1  request from the `tck` domain; level signal; asynchronous to `mem_clk`.
- `we`  in  1  1 = write, 0 = read; stable while `sel` = 1.
- `addr`  in  8  word address; stable while `sel` = 1.
- `wdata`  in  16  write data; stable while `sel` = 1.
- `ready`  out  1  1 = idle or access done; 0 = busy.
- `rdata`  out  16  read data; valid and stable whenever `ready` = 1 after a read.
- `dbg_addr`  in  8  debug port address for the bench.
- `dbg_rdata`  out  16  combinational `mem[dbg_addr]`; has no side effects.

## Operation
- Single clock `mem_clk`. Reset is asynchronous on the falling edge of `mem_rst_n` and released synchronously.
- `sel` passes through a `SYNC_STAGES`-deep synchronizer; its last stage is `sel_s`. `we`, `addr` and `wdata` are not synchronized; they are sampled only when `sel_s` rises.
- The memory array is 256x16 and is not reset. Its contents survive `mem_rst_n`.
- FSM has three states:
  - IDLE: `ready` = 1. If `sel_s` = 1, latch `we`/`addr`/`wdata` into internal registers, load the wait counter with `WAIT_STATES`, and go to ACCESS.
  - ACCESS: `ready` = 0. If the counter is nonzero, decrement it. If the counter is 0, commit the access and go to RELEASE:
    - write: `mem[addr_q]` <= `wdata_q`; `rdata` is unchanged.
    - read: `rdata` <= `mem[addr_q]`.
  - RELEASE: `ready` = 1. Wait for `sel_s` = 0, then go to IDLE. While `sel_s` stays 1, no new access starts, so one `sel` pulse produces exactly one access.
- `rdata` changes only at a read commit or at reset.
- Input changes on `we`/`addr`/`wdata` during ACCESS or RELEASE have no effect, because the latched copies are used.
- A read of an address that was written in the previous access returns the new data.
- Reset in ACCESS: the FSM returns to IDLE and the pending access is dropped. No memory write occurs, and `rdata` is forced to 0.
- Reset in RELEASE while `sel` is still high: after reset, `sel_s` = 1 in IDLE starts a new access. The initiator is responsible for this case, because a JTAG reset also clears `sel`.

## Timing
- Reset values: `ready` = 1 (matches the initiator's synchronizer reset of all ones); `rdata` = 0; state = IDLE; synchronizer = 0.
- Let cycle N be the first cycle with `sel_s` = 1 in IDLE:
  - `ready` falls at the N+1 edge.
  - The commit, the `rdata` update and `ready` rising all occur at the N+1+`WAIT_STATES`+1 edge.
  - `ready` is low for exactly `WAIT_STATES`+1 cycles.
- `sel` to `ready` falling: `SYNC_STAGES`+1 `mem_clk` edges.
- Constraints on the initiator:
  - The `ready` low pulse must last at least 3 `tck` periods. Size `WAIT_STATES` to meet this.
  - `sel` low must last at least `SYNC_STAGES`+1 `mem_clk` periods between requests. A shorter gap is not detected, and the next request is lost.
- `dbg_rdata` reflects a write in the cycle after the commit edge.

## Test plan
- Reset: assert `mem_rst_n` = 0 for 3 cycles -> `ready` = 1, `rdata` = 0x0000. `sel` = 0 held for 20 cycles -> `ready` stays 1.
- Write then read, `WAIT_STATES` = 2:
  - `sel` = 1, `we` = 1, `addr` = 0x3C, `wdata` = 0xA55A -> `ready` low for exactly 3 cycles, starting 3 edges after `sel`; `dbg_rdata`@0x3C = 0xA55A; `rdata` stays 0.
  - Drop `sel`; issue a read of 0x3C -> `rdata` = 0xA55A when `ready` rises.
- Held `sel`: keep `sel` = 1 for 50 cycles after `ready` returns -> exactly one access; `ready` stays 1. Change `addr` to 0x10 and `wdata` to 0xFFFF during the hold -> memory unchanged.
- Back-to-back writes of 0x0001 to 0x00 and 0xFFFE to 0xFF with a 3-cycle `sel` gap -> both writes stored; 0xFF wraps to the top word.
- Reset mid-access: start a write of 0x1234 to 0x05, where the old value at 0x05 is 0xBEEF. Pulse `mem_rst_n` during the second ACCESS cycle -> `dbg_rdata`@0x05 = 0xBEEF, `ready` = 1 and `rdata` = 0 immediately on reset.
- `WAIT_STATES` = 0 build: a read of 0x3C -> `ready` is low for exactly 1 cycle, and `rdata` is valid at the edge where `ready` rises.
